// File: rtl/rv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, funct
// fields, FSM states and every datapath select value.
package rv_pkg;

   // Major opcodes handled by the core
   localparam logic [6:0] OP_RTYPE  = 7'h33;
   localparam logic [6:0] OP_IALU   = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   // funct3 values
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_JALR = 3'b000;

   // funct7 values accepted for R-type
   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   // PC source
   localparam logic       PC_PLUS4  = 1'b0;
   localparam logic       PC_ALUOUT = 1'b1;
   // Register write-back source
   localparam logic [1:0] WB_MDR    = 2'd0;
   localparam logic [1:0] WB_ALUOUT = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;
   // Immediate format
   localparam logic [1:0] IMM_J     = 2'd0;
   localparam logic [1:0] IMM_B     = 2'd1;
   localparam logic [1:0] IMM_S     = 2'd2;
   localparam logic [1:0] IMM_I     = 2'd3;
   // ALU A operand
   localparam logic [1:0] ALUA_REG  = 2'd0;
   localparam logic [1:0] ALUA_ZERO = 2'd1;
   localparam logic [1:0] ALUA_PC   = 2'd2;
   // ALU B operand
   localparam logic       ALUB_REG  = 1'b0;
   localparam logic       ALUB_IMM  = 1'b1;
   // ALU operations
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   // Data memory address / write data sources
   localparam logic       ADDR_ALUOUT1 = 1'b0;
   localparam logic       ADDR_ALUOUT2 = 1'b1;
   localparam logic       DATAW_REGB   = 1'b0;
   localparam logic       DATAW_ALUOUT = 1'b1;

   // Opcodes that DECODE lets through (SYSTEM is accepted only to halt)
   function automatic logic opcode_known(input logic [6:0] op);
      case (op)
         OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE,
         OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM: opcode_known = 1'b1;
         default:                               opcode_known = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation decode for R-type and I-ALU instructions, with a legality
// flag for funct7 combinations the core does not implement.
module rv_alu_dec
   import rv_pkg::*;
(
   input  logic       is_rtype,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alusel,
   output logic       legal
);

   // funct3 picks the base op; funct7 selects SUB/SRA or flags the encoding
   always_comb begin
      alusel = ALU_ADD;
      legal  = 1'b1;
      case (funct3)
         F3_ADD:  alusel = ALU_ADD;
         F3_SLL:  alusel = ALU_SLL;
         F3_SLT:  alusel = ALU_SLT;
         F3_SLTU: alusel = ALU_SLTU;
         F3_XOR:  alusel = ALU_XOR;
         F3_SR:   alusel = ALU_SRL;
         F3_OR:   alusel = ALU_OR;
         F3_AND:  alusel = ALU_AND;
         default: alusel = ALU_ADD;
      endcase
      if (is_rtype) begin
         if (funct7 == F7_ALT) begin
            if (funct3 == F3_ADD)
               alusel = ALU_SUB;
            else if (funct3 == F3_SR)
               alusel = ALU_SRA;
            else
               legal = 1'b0;
         end else if (funct7 != F7_BASE) begin
            legal = 1'b0;
         end
      end else if (funct3 == F3_SR && funct7[5]) begin
         // SRAI encoding is flagged illegal; ADDI with any immediate stays ADD
         legal = 1'b0;
      end
   end

endmodule

// File: rtl/rv_ctl.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives all
// datapath selects and enables combinationally from state and instruction.
module rv_ctl
   import rv_pkg::*;
#(
   parameter int DPWIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DPWIDTH-1:0] instr,
   input  logic               zero,
   output logic               pcsourse,
   output logic               pcwrite,
   output logic               pccen,
   output logic               irwrite,
   output logic [1:0]         wbsel,
   output logic               regwen,
   output logic [1:0]         immsel,
   output logic [1:0]         asel,
   output logic               bsel,
   output logic [3:0]         alusel,
   output logic               mdrwrite,
   output logic               datawsel,
   output logic               addrsel,
   output logic               dmem_we,
   output logic               retire,
   output logic               halted,
   output logic               illegal
);

   state_t     state_reg, state_next;
   logic       halted_reg, illegal_reg;
   logic       set_halted, set_illegal;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [3:0] dec_alusel;
   logic       dec_legal;
   logic       exec_legal;
   logic       take;
   logic       unused_instr;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   // Register specifiers and immediates are consumed by the datapath only
   assign unused_instr = ^instr[24:7];

   rv_alu_dec u_alu_dec (
      .is_rtype (opcode == OP_RTYPE),
      .funct3   (funct3),
      .funct7   (funct7),
      .alusel   (dec_alusel),
      .legal    (dec_legal)
   );

   // Encoding checks that can only be made once the opcode is known
   always_comb begin
      case (opcode)
         OP_RTYPE, OP_IALU: exec_legal = dec_legal;
         OP_LOAD:           exec_legal = (funct3 == F3_LW);
         OP_STORE:          exec_legal = (funct3 == F3_SW);
         OP_BRANCH:         exec_legal = (funct3[2:1] != 2'b01);
         OP_JALR:           exec_legal = (funct3 == F3_JALR);
         OP_JAL:            exec_legal = 1'b1;
         default:           exec_legal = 1'b0;
      endcase
   end

   // Equality compares use zero directly; the SLT-based ones invert via funct3
   assign take = zero ^ (funct3[0] ^ funct3[2]);

   // Output and next-state decode; everything is forced idle while in reset
   always_comb begin
      pcsourse    = PC_PLUS4;
      pcwrite     = 1'b0;
      pccen       = 1'b0;
      irwrite     = 1'b0;
      wbsel       = WB_MDR;
      regwen      = 1'b0;
      immsel      = IMM_J;
      asel        = ALUA_REG;
      bsel        = ALUB_REG;
      alusel      = ALU_ADD;
      mdrwrite    = 1'b0;
      datawsel    = DATAW_REGB;
      addrsel     = ADDR_ALUOUT1;
      dmem_we     = 1'b0;
      retire      = 1'b0;
      set_halted  = 1'b0;
      set_illegal = 1'b0;
      state_next  = state_reg;
      if (!rst) begin
         case (state_reg)
            S_FETCH: begin
               irwrite    = 1'b1;
               pccen      = 1'b1;
               pcwrite    = 1'b1;
               pcsourse   = PC_PLUS4;
               state_next = S_DECODE;
            end
            S_DECODE: begin
               // Precompute the branch/jump target into ALUOUT
               asel   = ALUA_PC;
               bsel   = ALUB_IMM;
               alusel = ALU_ADD;
               immsel = (opcode == OP_JAL) ? IMM_J : IMM_B;
               if (!opcode_known(opcode)) begin
                  set_illegal = 1'b1;
                  state_next  = S_HALT;
               end else if (opcode == OP_SYSTEM) begin
                  set_halted = 1'b1;
                  state_next = S_HALT;
               end else begin
                  state_next = S_EXEC;
               end
            end
            S_EXEC: begin
               if (!exec_legal) begin
                  set_illegal = 1'b1;
                  state_next  = S_HALT;
               end else begin
                  case (opcode)
                     OP_RTYPE: begin
                        alusel     = dec_alusel;
                        state_next = S_WB;
                     end
                     OP_IALU: begin
                        bsel       = ALUB_IMM;
                        immsel     = IMM_I;
                        alusel     = dec_alusel;
                        state_next = S_WB;
                     end
                     OP_LOAD, OP_JALR: begin
                        bsel       = ALUB_IMM;
                        immsel     = IMM_I;
                        state_next = (opcode == OP_LOAD) ? S_MEM : S_WB;
                     end
                     OP_STORE: begin
                        bsel       = ALUB_IMM;
                        immsel     = IMM_S;
                        state_next = S_MEM;
                     end
                     OP_BRANCH: begin
                        case (funct3[2:1])
                           2'b00:   alusel = ALU_SUB;
                           2'b10:   alusel = ALU_SLT;
                           default: alusel = ALU_SLTU;
                        endcase
                        pcwrite    = take;
                        pcsourse   = PC_ALUOUT;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                     end
                     default: begin
                        // JAL: link and jump together, target came from DECODE
                        wbsel      = WB_PC;
                        regwen     = 1'b1;
                        pcwrite    = 1'b1;
                        pcsourse   = PC_ALUOUT;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                     end
                  endcase
               end
            end
            S_MEM: begin
               addrsel = ADDR_ALUOUT1;
               if (opcode == OP_LOAD) begin
                  mdrwrite   = 1'b1;
                  state_next = S_WB;
               end else begin
                  datawsel   = DATAW_REGB;
                  dmem_we    = 1'b1;
                  retire     = 1'b1;
                  state_next = S_FETCH;
               end
            end
            S_WB: begin
               regwen     = 1'b1;
               retire     = 1'b1;
               state_next = S_FETCH;
               if (opcode == OP_LOAD) begin
                  wbsel = WB_MDR;
               end else if (opcode == OP_JALR) begin
                  wbsel    = WB_PC;
                  pcwrite  = 1'b1;
                  pcsourse = PC_ALUOUT;
               end else begin
                  wbsel = WB_ALUOUT;
               end
            end
            default: state_next = S_HALT;
         endcase
      end
   end

   // State register and sticky status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= S_FETCH;
         halted_reg  <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (set_halted)
            halted_reg <= 1'b1;
         if (set_illegal)
            illegal_reg <= 1'b1;
      end
   end

   assign halted  = halted_reg;
   assign illegal = illegal_reg;

endmodule
